// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU/condition functions,
// register indices, instruction lengths and the condition-code record.
package y86_pkg;

  typedef enum logic [3:0] {
    IHALT   = 4'h0, INOP    = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ    = 4'h6, IJXX    = 4'h7,
    ICALL   = 4'h8, IRET    = 4'h9, IPUSHQ  = 4'hA, IPOPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_fn_e;

  typedef enum logic [3:0] {C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G} cond_fn_e;

  typedef enum logic [3:0] {
    RRAX, RRCX, RRDX, RRBX, RRSP, RRBP, RRSI, RRDI,
    RR8, RR9, RR10, RR11, RR12, RR13, RR14, RNONE = 4'hF
  } reg_e;

  typedef enum logic [3:0] {
    LEN_SHORT = 4'd1, LEN_REG = 4'd2, LEN_DEST = 4'd9, LEN_FULL = 4'd10
  } ilen_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic logic cond_eval(input cc_t cc, input logic [3:0] fn);
    case (fn)
      C_YES:   return 1'b1;
      C_LE:    return (cc.sf ^ cc.of) | cc.zf;
      C_L:     return cc.sf ^ cc.of;
      C_E:     return cc.zf;
      C_NE:    return ~cc.zf;
      C_GE:    return ~(cc.sf ^ cc.of);
      C_G:     return ~(cc.sf ^ cc.of) & ~cc.zf;
      default: return 1'b0;
    endcase
  endfunction

  // Undefined icodes are treated as one byte long for the address check.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  return LEN_REG;
      IJXX, ICALL:                   return LEN_DEST;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:     return LEN_FULL;
      default:                       return LEN_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/fde_regfile.sv
// 15x64 register file: two combinational read ports (index F reads 0),
// two synchronous write ports (port M wins on a collision), synchronous clear.
// Optional debug view of all registers under FDE_REG_DEBUG_EN.
import y86_pkg::*;

module fde_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rd_a_idx,
  input  logic [3:0]  rd_b_idx,
  output logic [63:0] rd_a_data,
  output logic [63:0] rd_b_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_e_idx,
  input  logic [63:0] wr_e_data,
  input  logic [3:0]  wr_m_idx,
  input  logic [63:0] wr_m_data
`ifdef FDE_REG_DEBUG_EN
  ,
  output logic [14:0][63:0] regs_out
`endif
);

  logic [63:0] regs [15];

  assign rd_a_data = (rd_a_idx == RNONE) ? '0 : regs[rd_a_idx];
  assign rd_b_data = (rd_b_idx == RNONE) ? '0 : regs[rd_b_idx];

  // NOTE: this storage is flops, not a RAM macro, so clearing every entry
  // on reset is legal and required; a true RAM could not be reset this way.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking updates; when both ports target the same entry
      // the later assignment (port M) is the one that lands.
      if (wr_e_idx != RNONE) regs[wr_e_idx] <= wr_e_data;
      if (wr_m_idx != RNONE) regs[wr_m_idx] <= wr_m_data;
    end
  end

`ifdef FDE_REG_DEBUG_EN
  always_comb begin
    for (int i = 0; i < 15; i++) regs_out[i] = regs[i];
  end
`endif

endmodule

// File: rtl/fetch_decode_execute.sv
// Single-cycle Y86-64 fetch, decode/writeback and execute.
// Define FDE_REG_DEBUG_EN to expose every architectural register as an output.
import y86_pkg::*;

module fetch_decode_execute #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [63:0] PC,
  input  logic [0:79] Instruction,
  input  logic [63:0] valM,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] valE,
  output logic        Condition,
  output logic [2:0]  CondititonCodes_Out,
  output logic        INS,
  output logic        ADR,
  output logic        HLT
`ifdef FDE_REG_DEBUG_EN
  ,
  output logic [63:0] rax, rbx, rcx, rdx, rsp, rbp, rsi, rdi,
  output logic [63:0] r8, r9, r10, r11, r12, r13, r14
`endif
);

  localparam logic [64:0] MEM_LIMIT = 65'(IMEM_BYTES);

  logic [3:0]  ilen, src_a, src_b, dst_e, dst_m;
  logic [63:0] alu_out;
  logic        commit;
  cc_t         cc, new_cc;

  // Fetch
  assign icode = Instruction[0:3];
  assign ifun  = Instruction[4:7];
  assign ilen  = instr_len(icode);
  assign valP  = PC + 64'(ilen);
  assign HLT   = (icode == IHALT);
  assign ADR   = ({1'b0, PC} + 65'(ilen)) > MEM_LIMIT;
  assign INS   = (icode > IPOPQ)
              || (!(icode inside {IRRMOVQ, IOPQ, IJXX}) && ifun != 4'd0)
              || ((icode == IRRMOVQ || icode == IJXX) && ifun > 4'd6)
              || (icode == IOPQ && ifun > 4'd3);
  assign commit = !(INS || ADR || HLT);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case arms can leave it unassigned (no latch).
    rA   = RNONE;
    rB   = RNONE;
    valC = '0;
    if (icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ}) begin
      rA = Instruction[8:11];
      rB = Instruction[12:15];
    end
    // Constants are little-endian: the lowest-addressed byte is the LSB.
    for (int k = 0; k < 8; k++) begin
      if (icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ})
        valC[8*k +: 8] = Instruction[8*(k+2) +: 8];
      else if (icode inside {IJXX, ICALL})
        valC[8*k +: 8] = Instruction[8*(k+1) +: 8];
    end
  end

  // Decode source selection
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = rA;
      IRET, IPOPQ:                    src_a = RRSP;
      default:                        src_a = RNONE;
    endcase
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         src_b = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RRSP;
      default:                        src_b = RNONE;
    endcase
  end

  // Execute: ALU and flags
  always_comb begin
    alu_out = '0;
    new_cc  = '0;
    case (ifun)
      ALU_ADD: alu_out = valB + valA;
      ALU_SUB: alu_out = valB - valA;
      ALU_AND: alu_out = valB & valA;
      ALU_XOR: alu_out = valB ^ valA;
      default: alu_out = '0;
    endcase
    new_cc.zf = (alu_out == '0);
    new_cc.sf = alu_out[63];
    if (ifun == ALU_ADD)
      new_cc.of = (valA[63] == valB[63]) && (alu_out[63] != valA[63]);
    else if (ifun == ALU_SUB)
      new_cc.of = (valA[63] != valB[63]) && (alu_out[63] != valB[63]);

    valE = '0;
    case (icode)
      IRRMOVQ:          valE = valA;
      IIRMOVQ:          valE = valC;
      IRMMOVQ, IMRMOVQ: valE = valB + valC;
      IOPQ:             valE = alu_out;
      ICALL, IPUSHQ:    valE = valB - 64'd8;
      IRET, IPOPQ:      valE = valB + 64'd8;
      default:          valE = '0;
    endcase
  end

  assign Condition = (icode == IRRMOVQ || icode == IJXX) ? cond_eval(cc, ifun) : 1'b0;

  // Writeback destinations
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IIRMOVQ, IOPQ:              dst_e = rB;
      IRRMOVQ:                    dst_e = Condition ? rB : RNONE;
      ICALL, IRET, IPUSHQ, IPOPQ: dst_e = RRSP;
      default:                    dst_e = RNONE;
    endcase
    if (icode == IMRMOVQ || icode == IPOPQ) dst_m = rA;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      cc <= '0;
    else if (commit && icode == IOPQ)
      cc <= new_cc;
  end

  assign CondititonCodes_Out = cc;

`ifdef FDE_REG_DEBUG_EN
  logic [14:0][63:0] dbg_regs;
`endif

  fde_regfile u_regfile (
    .clk       (Clk),
    .reset     (Reset),
    .rd_a_idx  (src_a),
    .rd_b_idx  (src_b),
    .rd_a_data (valA),
    .rd_b_data (valB),
    .wr_en     (commit),
    .wr_e_idx  (dst_e),
    .wr_e_data (valE),
    .wr_m_idx  (dst_m),
    .wr_m_data (valM)
`ifdef FDE_REG_DEBUG_EN
    ,
    .regs_out  (dbg_regs)
`endif
  );

`ifdef FDE_REG_DEBUG_EN
  assign rax = dbg_regs[RRAX];
  assign rcx = dbg_regs[RRCX];
  assign rdx = dbg_regs[RRDX];
  assign rbx = dbg_regs[RRBX];
  assign rsp = dbg_regs[RRSP];
  assign rbp = dbg_regs[RRBP];
  assign rsi = dbg_regs[RRSI];
  assign rdi = dbg_regs[RRDI];
  assign r8  = dbg_regs[RR8];
  assign r9  = dbg_regs[RR9];
  assign r10 = dbg_regs[RR10];
  assign r11 = dbg_regs[RR11];
  assign r12 = dbg_regs[RR12];
  assign r13 = dbg_regs[RR13];
  assign r14 = dbg_regs[RR14];
`endif

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Scoreboard bench for fetch_decode_execute: stimulus pushes expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_fetch_decode_execute;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [63:0] PC;
  logic [0:79] Instruction;
  logic [63:0] valM;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valA, valB, valE;
  logic        Condition;
  logic [2:0]  CondititonCodes_Out;
  logic        INS, ADR, HLT;

  fetch_decode_execute #(.IMEM_BYTES(1024)) dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .Instruction(Instruction), .valM(valM),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .valA(valA), .valB(valB), .valE(valE), .Condition(Condition),
    .CondititonCodes_Out(CondititonCodes_Out), .INS(INS), .ADR(ADR), .HLT(HLT)
  );

  always #5 Clk = ~Clk;

  typedef enum {S_ICODE, S_RA, S_RB, S_VALC, S_VALP, S_VALA, S_VALB, S_VALE,
                S_COND, S_CC, S_INS, S_ADR, S_HLT} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [63:0] actual(input sig_e s);
    case (s)
      S_ICODE: return 64'(icode);
      S_RA:    return 64'(rA);
      S_RB:    return 64'(rB);
      S_VALC:  return valC;
      S_VALP:  return valP;
      S_VALA:  return valA;
      S_VALB:  return valB;
      S_VALE:  return valE;
      S_COND:  return 64'(Condition);
      S_CC:    return 64'(CondititonCodes_Out);
      S_INS:   return 64'(INS);
      S_ADR:   return 64'(ADR);
      S_HLT:   return 64'(HLT);
      default: return 'x;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational and stable by the falling edge.
  always @(negedge Clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, actual(e.sig), e.exp);
    end
  end

  task automatic push_exp(input string name, input sig_e s, input logic [63:0] v);
    exp_t e;
    e.name = name; e.sig = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] le64(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[63-8*k -: 8] = v[8*k +: 8];
    return r;
  endfunction

  task automatic drive(input logic [79:0] ins, input logic [63:0] pc = 64'd0,
                       input logic [63:0] vm = 64'd0);
    Instruction = ins;
    PC = pc;
    valM = vm;
  endtask

  function automatic logic [79:0] irmovq(input logic [3:0] r, input logic [63:0] v);
    return {8'h30, 4'hF, r, le64(v)};
  endfunction

  // rmmovq reads R[ra] on valA and R[rb] on valB without writing anything.
  task automatic peek(input logic [3:0] ra, input logic [3:0] rb);
    drive({8'h40, ra, rb, 64'h0});
  endtask

  task automatic set_reg(input logic [3:0] r, input logic [63:0] v);
    drive(irmovq(r, v));
    step();
  endtask

  initial begin
    Reset = 1'b1;
    drive(80'h0);
    step();
    step();

    // Reset state, observed while reset is still asserted
    peek(4'h0, 4'h3);
    push_exp("reset_valA", S_VALA, 64'd0);
    push_exp("reset_valB", S_VALB, 64'd0);
    push_exp("reset_cc",   S_CC,   64'd0);
    step();
    Reset = 1'b0;

    // irmovq $10, %rbx
    drive(80'h30F3_0A00_0000_0000_0000);
    push_exp("irm_icode", S_ICODE, 64'h3);
    push_exp("irm_rA",    S_RA,    64'hF);
    push_exp("irm_rB",    S_RB,    64'h3);
    push_exp("irm_valC",  S_VALC,  64'd10);
    push_exp("irm_valP",  S_VALP,  64'd10);
    push_exp("irm_valE",  S_VALE,  64'd10);
    push_exp("irm_ins",   S_INS,   64'd0);
    push_exp("irm_adr",   S_ADR,   64'd0);
    push_exp("irm_hlt",   S_HLT,   64'd0);
    step();
    peek(4'h0, 4'h3);
    push_exp("irm_rbx", S_VALB, 64'd10);
    step();

    // subq %rax,%rbx : 10 - 5
    set_reg(4'h0, 64'd5);
    drive({16'h6103, 64'h0});
    push_exp("sub_valA", S_VALA, 64'd5);
    push_exp("sub_valB", S_VALB, 64'd10);
    push_exp("sub_valE", S_VALE, 64'd5);
    step();
    peek(4'h0, 4'h3);
    push_exp("sub_rbx", S_VALB, 64'd5);
    push_exp("sub_cc",  S_CC,   64'b000);
    step();

    // subq to zero, then cmove with ZF set
    set_reg(4'h0, 64'd7);
    set_reg(4'h3, 64'd7);
    drive({16'h6103, 64'h0});
    push_exp("subz_valE", S_VALE, 64'd0);
    step();
    peek(4'h0, 4'h3);
    push_exp("subz_rbx", S_VALB, 64'd0);
    push_exp("subz_cc",  S_CC,   64'b100);
    step();
    drive({16'h2303, 64'h0});
    push_exp("cmove_taken_cond", S_COND, 64'd1);
    push_exp("cmove_taken_valE", S_VALE, 64'd7);
    step();
    peek(4'h0, 4'h3);
    push_exp("cmove_taken_rbx", S_VALB, 64'd7);
    step();

    // cmove with ZF clear: no write
    set_reg(4'h3, 64'd9);
    drive({16'h6103, 64'h0});
    push_exp("sub2_valE", S_VALE, 64'd2);
    step();
    drive({16'h2303, 64'h0});
    push_exp("cmove_nt_cond", S_COND, 64'd0);
    step();
    peek(4'h0, 4'h3);
    push_exp("cmove_nt_rbx", S_VALB, 64'd2);
    push_exp("cmove_nt_cc",  S_CC,   64'b000);
    step();

    // addq overflow
    set_reg(4'h0, 64'h7FFF_FFFF_FFFF_FFFF);
    set_reg(4'h3, 64'd1);
    drive({16'h6003, 64'h0});
    push_exp("addov_valE", S_VALE, 64'h8000_0000_0000_0000);
    step();
    peek(4'h0, 4'h3);
    push_exp("addov_cc", S_CC, 64'b011);
    step();

    // jg taken, jl not taken with SF=OF=1, ZF=0
    drive({8'h76, le64(64'h123), 8'h00});
    push_exp("jg_cond", S_COND, 64'd1);
    push_exp("jg_valC", S_VALC, 64'h123);
    push_exp("jg_valP", S_VALP, 64'd9);
    step();
    drive({8'h72, le64(64'h123), 8'h00});
    push_exp("jl_cond", S_COND, 64'd0);
    step();

    // pushq %rax
    set_reg(4'h4, 64'h100);
    drive({16'hA00F, 64'h0});
    push_exp("push_valA", S_VALA, 64'h7FFF_FFFF_FFFF_FFFF);
    push_exp("push_valB", S_VALB, 64'h100);
    push_exp("push_valE", S_VALE, 64'hF8);
    step();
    peek(4'h3, 4'h4);
    push_exp("push_rsp", S_VALB, 64'hF8);
    step();

    // popq %rbx with valM = 0x55
    drive({16'hB03F, 64'h0}, 64'd0, 64'h55);
    push_exp("pop_valA", S_VALA, 64'hF8);
    push_exp("pop_valE", S_VALE, 64'h100);
    step();
    peek(4'h3, 4'h4);
    push_exp("pop_rbx", S_VALA, 64'h55);
    push_exp("pop_rsp", S_VALB, 64'h100);
    step();

    // popq %rsp: valM wins over valE
    drive({16'hB04F, 64'h0}, 64'd0, 64'h77);
    push_exp("poprsp_valE", S_VALE, 64'h108);
    step();
    peek(4'h0, 4'h4);
    push_exp("poprsp_rsp", S_VALB, 64'h77);
    step();

    // Invalid OPq function: no register or CC write
    set_reg(4'h0, 64'd1);
    set_reg(4'h3, 64'd1);
    drive({16'h6703, 64'h0});
    push_exp("badop_ins", S_INS, 64'd1);
    step();
    peek(4'h0, 4'h3);
    push_exp("badop_rbx", S_VALB, 64'd1);
    push_exp("badop_cc",  S_CC,   64'b011);
    step();

    drive({16'hC000, 64'h0});
    push_exp("icodeC_ins", S_INS, 64'd1);
    step();

    drive(80'h0, 64'h20);
    push_exp("halt_hlt",  S_HLT,  64'd1);
    push_exp("halt_valP", S_VALP, 64'h21);
    push_exp("halt_ins",  S_INS,  64'd0);
    step();

    // Address boundary
    drive(irmovq(4'h3, 64'hAA), 64'd1023);
    push_exp("adr_hi_adr",  S_ADR,  64'd1);
    push_exp("adr_hi_valP", S_VALP, 64'd1033);
    step();
    peek(4'h0, 4'h3);
    push_exp("adr_hi_rbx", S_VALB, 64'd1);
    step();
    drive(irmovq(4'h3, 64'hBB), 64'd1014);
    push_exp("adr_edge_adr", S_ADR, 64'd0);
    step();
    peek(4'h0, 4'h3);
    push_exp("adr_edge_rbx", S_VALB, 64'hBB);
    step();

    // Reset overrides a pending write
    Reset = 1'b1;
    drive(irmovq(4'h3, 64'hCC));
    step();
    Reset = 1'b0;
    peek(4'h0, 4'h3);
    push_exp("rst2_valA", S_VALA, 64'd0);
    push_exp("rst2_valB", S_VALB, 64'd0);
    push_exp("rst2_cc",   S_CC,   64'd0);
    step();

    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
